// File: rtl/calc_req_scheduler.sv
// Four-port round-robin front end for a shared calculator ALU.
// Collects two-cycle requests, issues one operation at a time, and routes results back.
module calc_req_scheduler #(
    parameter int NPORTS  = 4,
    parameter int TIMEOUT = 16,
    parameter int DW      = 32
) (
    input  logic          c_clk,
    input  logic          reset,
    input  logic [3:0]    req1_cmd_in,
    input  logic [DW-1:0] req1_data_in,
    input  logic [3:0]    req2_cmd_in,
    input  logic [DW-1:0] req2_data_in,
    input  logic [3:0]    req3_cmd_in,
    input  logic [DW-1:0] req3_data_in,
    input  logic [3:0]    req4_cmd_in,
    input  logic [DW-1:0] req4_data_in,
    output logic [1:0]    out_resp1,
    output logic [DW-1:0] out_data1,
    output logic [1:0]    out_resp2,
    output logic [DW-1:0] out_data2,
    output logic [1:0]    out_resp3,
    output logic [DW-1:0] out_data3,
    output logic [1:0]    out_resp4,
    output logic [DW-1:0] out_data4,
    output logic          alu_valid_out,
    output logic [3:0]    alu_cmd_out,
    output logic [DW-1:0] alu_op1_out,
    output logic [DW-1:0] alu_op2_out,
    input  logic [1:0]    alu_resp_in,
    input  logic [DW-1:0] alu_data_in,
    output logic [7:0]    drop_cnt
);

    typedef enum logic [1:0] {IDLE, OP2, PEND, WAIT} portState_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]    w_cmdIn  [NPORTS];
    logic [DW-1:0] w_dataIn [NPORTS];

    portState_t    r_state     [NPORTS];
    portState_t    w_stateNext [NPORTS];
    logic [3:0]    r_cmd       [NPORTS];
    logic [DW-1:0] r_op1       [NPORTS];
    logic [DW-1:0] r_op2       [NPORTS];
    logic [1:0]    r_resp      [NPORTS];
    logic [DW-1:0] r_data      [NPORTS];
    logic [NPORTS-1:0] r_rej;

    logic          r_busy;
    logic [1:0]    r_owner;
    logic [1:0]    r_ptr;
    logic [TW-1:0] r_tmr;
    logic          r_aluValid;
    logic [3:0]    r_aluCmd;
    logic [DW-1:0] r_aluOp1;
    logic [DW-1:0] r_aluOp2;
    logic [7:0]    r_dropCnt;

    logic [NPORTS-1:0] w_pend;
    logic [NPORTS-1:0] w_accept;
    logic [NPORTS-1:0] w_drop;
    logic [NPORTS-1:0] w_release;
    logic              w_done;
    logic              w_tmo;
    logic              w_aluFree;
    logic [2:0]        w_pick;
    logic              w_grant;
    logic [1:0]        w_grantIdx;
    logic [2:0]        w_dropSum;
    logic [8:0]        w_dropTotal;

    assign w_cmdIn[0]  = req1_cmd_in;
    assign w_cmdIn[1]  = req2_cmd_in;
    assign w_cmdIn[2]  = req3_cmd_in;
    assign w_cmdIn[3]  = req4_cmd_in;
    assign w_dataIn[0] = req1_data_in;
    assign w_dataIn[1] = req2_data_in;
    assign w_dataIn[2] = req3_data_in;
    assign w_dataIn[3] = req4_data_in;

    function automatic logic isValidCmd(input logic [3:0] cmd);
        return (cmd == 4'd1) || (cmd == 4'd2) || (cmd == 4'd5) || (cmd == 4'd6);
    endfunction

    // Returns {found, index} of the first pending port at or after ptr.
    function automatic logic [2:0] pickPort(input logic [3:0] pend, input logic [1:0] ptr);
        logic [1:0] idx;
        pickPort = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (pend[idx]) begin
                pickPort = {1'b1, idx};
            end
        end
    endfunction

    // A completion always wins over a timeout that lands on the same edge.
    assign w_done    = r_busy && (alu_resp_in != 2'd0);
    assign w_tmo     = r_busy && !w_done && (r_tmr == TW'(TIMEOUT));
    assign w_aluFree = !r_busy || w_done || w_tmo;

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                r_state[p] <= IDLE;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                r_state[p] <= w_stateNext[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            w_stateNext[p] = r_state[p];
            case (r_state[p])
                IDLE: if (w_accept[p]) w_stateNext[p] = OP2;
                OP2:  w_stateNext[p] = isValidCmd(r_cmd[p]) ? PEND : IDLE;
                PEND: if (w_grant && (w_grantIdx == 2'(p))) w_stateNext[p] = WAIT;
                WAIT: if (w_release[p]) w_stateNext[p] = IDLE;
                default: w_stateNext[p] = IDLE;
            endcase
        end
    end

    // The cycle after a rejected command still counts as busy for new commands.
    always_comb begin
        w_pend    = '0;
        w_accept  = '0;
        w_drop    = '0;
        w_release = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_pend[p]    = (r_state[p] == PEND);
            w_accept[p]  = (r_state[p] == IDLE) && !r_rej[p] && (w_cmdIn[p] != 4'd0);
            w_drop[p]    = (w_cmdIn[p] != 4'd0) &&
                           ((r_state[p] == PEND) || (r_state[p] == WAIT) ||
                            ((r_state[p] == IDLE) && r_rej[p]));
            w_release[p] = (w_done || w_tmo) && (r_owner == 2'(p));
        end
    end

    always_comb begin
        w_pick     = pickPort(w_pend, r_ptr);
        w_grant    = w_aluFree && w_pick[2];
        w_grantIdx = w_pick[1:0];
    end

    always_comb begin
        w_dropSum = 3'd0;
        for (int p = 0; p < NPORTS; p++) begin
            w_dropSum = w_dropSum + 3'(w_drop[p]);
        end
        w_dropTotal = {1'b0, r_dropCnt} + 9'(w_dropSum);
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                r_cmd[p]  <= 4'd0;
                r_op1[p]  <= '0;
                r_op2[p]  <= '0;
                r_resp[p] <= 2'd0;
                r_data[p] <= '0;
            end
            r_rej      <= '0;
            r_busy     <= 1'b0;
            r_owner    <= 2'd0;
            r_ptr      <= 2'd0;
            r_tmr      <= '0;
            r_aluValid <= 1'b0;
            r_aluCmd   <= 4'd0;
            r_aluOp1   <= '0;
            r_aluOp2   <= '0;
            r_dropCnt  <= 8'd0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (w_accept[p]) begin
                    r_cmd[p] <= w_cmdIn[p];
                    r_op1[p] <= w_dataIn[p];
                end
                if (r_state[p] == OP2) begin
                    r_op2[p] <= w_dataIn[p];
                end
                r_rej[p] <= (r_state[p] == OP2) && !isValidCmd(r_cmd[p]);
                if (r_rej[p]) begin
                    r_resp[p] <= 2'd3;
                    r_data[p] <= '0;
                end else if (w_release[p] && w_done) begin
                    r_resp[p] <= alu_resp_in;
                    r_data[p] <= alu_data_in;
                end else if (w_release[p]) begin
                    r_resp[p] <= 2'd3;
                    r_data[p] <= '0;
                end else begin
                    r_resp[p] <= 2'd0;
                    r_data[p] <= '0;
                end
            end

            r_aluValid <= w_grant;
            if (w_grant) begin
                r_aluCmd <= r_cmd[w_grantIdx];
                r_aluOp1 <= r_op1[w_grantIdx];
                r_aluOp2 <= r_op2[w_grantIdx];
                r_owner  <= w_grantIdx;
                r_ptr    <= w_grantIdx + 2'd1;
                r_busy   <= 1'b1;
                r_tmr    <= '0;
            end else begin
                r_aluCmd <= 4'd0;
                r_aluOp1 <= '0;
                r_aluOp2 <= '0;
                if (w_done || w_tmo) begin
                    r_busy <= 1'b0;
                end else if (r_busy) begin
                    r_tmr <= r_tmr + TW'(1);
                end
            end

            r_dropCnt <= (w_dropTotal > 9'd255) ? 8'hFF : w_dropTotal[7:0];
        end
    end

    assign out_resp1     = r_resp[0];
    assign out_data1     = r_data[0];
    assign out_resp2     = r_resp[1];
    assign out_data2     = r_data[1];
    assign out_resp3     = r_resp[2];
    assign out_data3     = r_data[2];
    assign out_resp4     = r_resp[3];
    assign out_data4     = r_data[3];
    assign alu_valid_out = r_aluValid;
    assign alu_cmd_out   = r_aluCmd;
    assign alu_op1_out   = r_aluOp1;
    assign alu_op2_out   = r_aluOp2;
    assign drop_cnt      = r_dropCnt;

endmodule

// File: tb/tb_calc_req_scheduler.sv
// Scoreboard bench for calc_req_scheduler with a behavioural ALU that can stall or answer late.
module tb_calc_req_scheduler;

    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    reqCmd  [4];
    logic [DW-1:0] reqData [4];
    logic [1:0]    outResp [4];
    logic [DW-1:0] outData [4];
    logic          aluValid;
    logic [3:0]    aluCmd;
    logic [DW-1:0] aluOp1;
    logic [DW-1:0] aluOp2;
    logic [1:0]    aluResp;
    logic [DW-1:0] aluData;
    logic [7:0]    dropCnt;

    typedef struct {
        int            port;
        logic [1:0]    resp;
        logic [DW-1:0] data;
        int            cyc;
    } respExp_t;

    typedef struct {
        logic [3:0]    cmd;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        int            cyc;
    } issueExp_t;

    respExp_t  respQ[$];
    issueExp_t issueQ[$];

    int cycleCnt = 0;
    int checkCnt = 0;
    int passCnt  = 0;
    bit monOn    = 1'b0;

    int            aluDelay  = 1;
    bit            hangNext  = 1'b0;
    bit            pendArmed = 1'b0;
    int            pendDue   = 0;
    logic [1:0]    pendResp;
    logic [DW-1:0] pendData;
    bit            lateArmed = 1'b0;
    int            lateDue   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    calc_req_scheduler #(.NPORTS(4), .TIMEOUT(TIMEOUT), .DW(DW)) dut (
        .c_clk         (clk),
        .reset         (reset),
        .req1_cmd_in   (reqCmd[0]),
        .req1_data_in  (reqData[0]),
        .req2_cmd_in   (reqCmd[1]),
        .req2_data_in  (reqData[1]),
        .req3_cmd_in   (reqCmd[2]),
        .req3_data_in  (reqData[2]),
        .req4_cmd_in   (reqCmd[3]),
        .req4_data_in  (reqData[3]),
        .out_resp1     (outResp[0]),
        .out_data1     (outData[0]),
        .out_resp2     (outResp[1]),
        .out_data2     (outData[1]),
        .out_resp3     (outResp[2]),
        .out_data3     (outData[2]),
        .out_resp4     (outResp[3]),
        .out_data4     (outData[3]),
        .alu_valid_out (aluValid),
        .alu_cmd_out   (aluCmd),
        .alu_op1_out   (aluOp1),
        .alu_op2_out   (aluOp2),
        .alu_resp_in   (aluResp),
        .alu_data_in   (aluData),
        .drop_cnt      (dropCnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        if (obs === exp) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycleCnt);
        end
    endtask

    // Reference ALU behaviour: add/sub flag carry/borrow with resp 2.
    task automatic aluCompute(input logic [3:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              output logic [1:0] r, output logic [DW-1:0] d);
        logic [DW:0] wide;
        case (cmd)
            4'd1: begin
                wide = {1'b0, a} + {1'b0, b};
                d    = wide[DW-1:0];
                r    = wide[DW] ? 2'd2 : 2'd1;
            end
            4'd2: begin
                d = a - b;
                r = (a < b) ? 2'd2 : 2'd1;
            end
            4'd5: begin
                d = a << b[4:0];
                r = 2'd1;
            end
            4'd6: begin
                d = a >> b[4:0];
                r = 2'd1;
            end
            default: begin
                d = '0;
                r = 2'd3;
            end
        endcase
    endtask

    task automatic expectIssue(input logic [3:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input int cyc);
        issueQ.push_back('{cmd, a, b, cyc});
    endtask

    task automatic expectResp(input int port, input logic [1:0] r, input logic [DW-1:0] d, input int cyc);
        respQ.push_back('{port, r, d, cyc});
    endtask

    task automatic expectOp(input int port, input logic [3:0] cmd, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input int issueCyc, input int delay);
        logic [1:0]    r;
        logic [DW-1:0] d;
        aluCompute(cmd, a, b, r, d);
        expectIssue(cmd, a, b, issueCyc);
        expectResp(port, r, d, issueCyc + delay + 1);
    endtask

    // Called on a falling edge; commands are sampled at the next rising edge.
    task automatic applyStimulus(input logic [3:0][3:0] cmds, input logic [3:0][DW-1:0] op1,
                                 input logic [3:0][DW-1:0] op2);
        for (int p = 0; p < 4; p++) begin
            if (cmds[p] != 4'd0) begin
                reqCmd[p]  = cmds[p];
                reqData[p] = op1[p];
            end
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            if (cmds[p] != 4'd0) begin
                reqCmd[p]  = 4'd0;
                reqData[p] = op2[p];
            end
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            if (cmds[p] != 4'd0) begin
                reqData[p] = '0;
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int p = 0; p < 4; p++) begin
            checkOutput($sformatf("%s_resp%0d", tag, p + 1), 64'(outResp[p]), 64'd0);
            checkOutput($sformatf("%s_data%0d", tag, p + 1), 64'(outData[p]), 64'd0);
        end
        checkOutput($sformatf("%s_aluValid", tag), 64'(aluValid), 64'd0);
        checkOutput($sformatf("%s_aluBus", tag), {28'd0, aluCmd, aluOp1 | aluOp2}, 64'd0);
        checkOutput($sformatf("%s_dropCnt", tag), 64'(dropCnt), 64'd0);
    endtask

    // Behavioural ALU plus response and issue monitors.
    always @(negedge clk) begin
        int idx;
        issueExp_t ie;
        aluResp = 2'd0;
        aluData = '0;
        if (pendArmed && (cycleCnt == pendDue)) begin
            aluResp   = pendResp;
            aluData   = pendData;
            pendArmed = 1'b0;
        end
        if (lateArmed && (cycleCnt == lateDue)) begin
            aluResp   = 2'd1;
            aluData   = 32'hDEAD_BEEF;
            lateArmed = 1'b0;
        end
        if (monOn) begin
            if (aluValid === 1'b1) begin
                if (issueQ.size() == 0) begin
                    checkOutput("unexpIssue", 64'(aluValid), 64'd0);
                end else begin
                    ie = issueQ.pop_front();
                    checkOutput("issueCmd", 64'(aluCmd), 64'(ie.cmd));
                    checkOutput("issueOp1", 64'(aluOp1), 64'(ie.op1));
                    checkOutput("issueOp2", 64'(aluOp2), 64'(ie.op2));
                    checkOutput("issueCycle", 64'(cycleCnt), 64'(ie.cyc));
                end
                if (hangNext) begin
                    hangNext  = 1'b0;
                    lateArmed = 1'b1;
                    lateDue   = cycleCnt + TIMEOUT + 3;
                end else begin
                    aluCompute(aluCmd, aluOp1, aluOp2, pendResp, pendData);
                    pendArmed = 1'b1;
                    pendDue   = cycleCnt + aluDelay;
                end
            end else if ((aluCmd !== 4'd0) || (aluOp1 !== '0) || (aluOp2 !== '0)) begin
                checkOutput("aluIdleBus", {28'd0, aluCmd, aluOp1 | aluOp2}, 64'd0);
            end

            for (int p = 0; p < 4; p++) begin
                if (outResp[p] !== 2'd0) begin
                    idx = -1;
                    for (int i = 0; i < respQ.size(); i++) begin
                        if ((idx < 0) && (respQ[i].port == p)) idx = i;
                    end
                    if (idx < 0) begin
                        checkOutput($sformatf("unexpResp%0d", p + 1), 64'(outResp[p]), 64'd0);
                    end else begin
                        checkOutput($sformatf("resp%0d", p + 1), 64'(outResp[p]), 64'(respQ[idx].resp));
                        checkOutput($sformatf("data%0d", p + 1), 64'(outData[p]), 64'(respQ[idx].data));
                        checkOutput($sformatf("respCycle%0d", p + 1), 64'(cycleCnt), 64'(respQ[idx].cyc));
                        respQ.delete(idx);
                    end
                end else if (outData[p] !== '0) begin
                    checkOutput($sformatf("idleData%0d", p + 1), 64'(outData[p]), 64'd0);
                end
            end

            for (int i = respQ.size() - 1; i >= 0; i--) begin
                if (respQ[i].cyc < cycleCnt) begin
                    checkOutput($sformatf("missedResp%0d", respQ[i].port + 1), 64'(cycleCnt), 64'(respQ[i].cyc));
                    respQ.delete(i);
                end
            end
            if ((issueQ.size() != 0) && (issueQ[0].cyc < cycleCnt)) begin
                checkOutput("missedIssue", 64'(cycleCnt), 64'(issueQ[0].cyc));
                void'(issueQ.pop_front());
            end
        end
    end

    initial begin
        logic [3:0][3:0]    cmds;
        logic [3:0][DW-1:0] a;
        logic [3:0][DW-1:0] b;
        int t;

        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            reqCmd[p]  = 4'd0;
            reqData[p] = '0;
        end
        aluResp = 2'd0;
        aluData = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        monOn = 1'b1;

        // Single uncontended add on port 1.
        @(negedge clk);
        t = cycleCnt + 1;
        expectIssue(4'd1, 32'd5, 32'd1, t + 2);
        expectResp(0, 2'd1, 32'd6, t + 4);
        cmds = '0; a = '0; b = '0;
        cmds[0] = 4'd1; a[0] = 32'd5; b[0] = 32'd1;
        applyStimulus(cmds, a, b);
        repeat (6) @(negedge clk);

        // Reset puts the pointer back on port 1, then all four ports contend.
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("reset2");
        reset = 1'b0;
        @(negedge clk);
        t = cycleCnt + 1;
        cmds = '0; a = '0; b = '0;
        for (int p = 0; p < 4; p++) begin
            cmds[p] = 4'd2;
            a[p]    = 32'(50 + p);
            b[p]    = 32'(p + 1);
            expectOp(p, 4'd2, a[p], b[p], t + 2 + 2 * p, 1);
        end
        applyStimulus(cmds, a, b);
        repeat (12) @(negedge clk);

        // Port 1 alone moves the pointer to port 2; then ports 1 and 4 contend.
        t = cycleCnt + 1;
        cmds = '0; a = '0; b = '0;
        cmds[0] = 4'd2; a[0] = 32'd3; b[0] = 32'd4;
        expectOp(0, 4'd2, 32'd3, 32'd4, t + 2, 1);
        applyStimulus(cmds, a, b);
        repeat (4) @(negedge clk);
        t = cycleCnt + 1;
        cmds = '0; a = '0; b = '0;
        cmds[3] = 4'd5; a[3] = 32'd1;    b[3] = 32'd4;
        cmds[0] = 4'd6; a[0] = 32'h80;  b[0] = 32'd3;
        expectOp(3, 4'd5, 32'd1, 32'd4, t + 2, 1);
        expectOp(0, 4'd6, 32'h80, 32'd3, t + 4, 1);
        applyStimulus(cmds, a, b);
        repeat (8) @(negedge clk);

        // Invalid commands on ports 1 and 3 in the same cycle.
        t = cycleCnt + 1;
        cmds = '0; a = '0; b = '0;
        cmds[2] = 4'h3; a[2] = 32'd11; b[2] = 32'd12;
        cmds[0] = 4'hF; a[0] = 32'd13; b[0] = 32'd14;
        expectResp(2, 2'd3, 32'd0, t + 2);
        expectResp(0, 2'd3, 32'd0, t + 2);
        applyStimulus(cmds, a, b);
        repeat (4) @(negedge clk);

        // Hung ALU on port 2, port 3 waiting behind it, late answer afterwards.
        hangNext = 1'b1;
        t = cycleCnt + 1;
        cmds = '0; a = '0; b = '0;
        cmds[1] = 4'd1; a[1] = 32'd9;  b[1] = 32'd2;
        cmds[2] = 4'd1; a[2] = 32'd20; b[2] = 32'd22;
        expectIssue(4'd1, 32'd9, 32'd2, t + 2);
        expectResp(1, 2'd3, 32'd0, t + 2 + TIMEOUT + 1);
        expectOp(2, 4'd1, 32'd20, 32'd22, t + 2 + TIMEOUT + 1, 1);
        applyStimulus(cmds, a, b);
        repeat (TIMEOUT + 10) @(negedge clk);

        // Second command on port 2 while it waits on a slow ALU gets dropped.
        aluDelay = 3;
        t = cycleCnt + 1;
        cmds = '0; a = '0; b = '0;
        cmds[1] = 4'd1; a[1] = 32'd7; b[1] = 32'd8;
        expectOp(1, 4'd1, 32'd7, 32'd8, t + 2, 3);
        applyStimulus(cmds, a, b);
        repeat (2) @(negedge clk);
        a[1] = 32'd70; b[1] = 32'd80;
        applyStimulus(cmds, a, b);
        checkOutput("dropCnt", 64'(dropCnt), 64'd1);
        repeat (6) @(negedge clk);

        // Reset while port 4 waits; the ALU answer that follows must be ignored.
        aluDelay = 5;
        t = cycleCnt + 1;
        cmds = '0; a = '0; b = '0;
        cmds[3] = 4'd2; a[3] = 32'd20; b[3] = 32'd5;
        expectIssue(4'd2, 32'd20, 32'd5, t + 2);
        applyStimulus(cmds, a, b);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midReset");
        reset = 1'b0;
        aluDelay = 1;
        repeat (10) @(negedge clk);

        checkOutput("respQueueEmpty", 64'(respQ.size()), 64'd0);
        checkOutput("issueQueueEmpty", 64'(issueQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
